// File: rtl/gray_counter.sv
// gray_counter: parametrised up/down binary counter with a registered Gray-code
// copy, parallel load, terminal-count flag and a one-cycle wrap pulse.
// Optional build macro: GRAY_COUNTER_SATURATE_EN -- when defined, an enabled
// count at the terminal value for the current direction holds instead of wrapping.
// The Gray output is encoded from the next-state binary value and registered,
// so it never glitches and changes exactly one bit per count step.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_terminal;

    // Terminal value depends on direction: all-ones counting up, zero counting down.
    assign at_terminal = up ? (bin_q == {WIDTH{1'b1}}) : (bin_q == {WIDTH{1'b0}});

    // Next binary value and wrap pulse: load beats count; idle holds the count.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (!at_terminal) begin
                bin_d = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
            end
`else
            bin_d  = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
            wrap_d = at_terminal;
`endif
        end
    end

    // Gray encoding of the next-state value: each bit XORs with its upper neighbour.
    assign gray_d[WIDTH-1] = bin_d[WIDTH-1];
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_d[gi] = bin_d[gi] ^ bin_d[gi+1];
        end
    endgenerate

    // State registers; reset clears everything on the edge it is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;
    assign tc   = at_terminal;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at WIDTH=4.
// Expected values are hand-computed; the saturating build is covered when
// GRAY_COUNTER_SATURATE_EN is defined for both bench and design.
module tb_gray_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             tc;
    logic             wrap;

    int n_compared   = 0;
    int n_mismatched = 0;
    int gray_tab [16];
    logic [WIDTH-1:0] prev_gray;

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic check_val(input string tag, input int obs, input int exp_val);
        n_compared++;
        if (obs != exp_val) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int eb, input int eg, input int ew);
        check_val({tag, ".bin"}, int'(bin), eb);
        check_val({tag, ".gray"}, int'(gray), eg);
        check_val({tag, ".wrap"}, int'(wrap), ew);
        $display("txn %s: bin=%0d gray=%0d wrap=%0d tc=%0d", tag, bin, gray, wrap, tc);
    endtask

    initial begin
        gray_tab = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
        #2;
        tick();
        tick();
        check_state("reset", 0, 0, 0);
        check_val("reset.tc_up", int'(tc), 0);
        up = 1'b0; #1;
        check_val("reset.tc_down", int'(tc), 1);

        // Full up sweep 0..15
        rst = 1'b0; en = 1'b1; up = 1'b1; #1;
        prev_gray = gray;
        for (int i = 0; i < 16; i++) begin
            check_state($sformatf("up%0d", i), i, gray_tab[i], 0);
            check_val($sformatf("up%0d.tc", i), int'(tc), (i == 15) ? 1 : 0);
            if (i > 0)
                check_val($sformatf("up%0d.hamming", i), $countones(gray ^ prev_gray), 1);
            prev_gray = gray;
            if (i < 15) tick();
        end

        // One more up count at 15
`ifdef GRAY_COUNTER_SATURATE_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("sat_up%0d", i), 15, 8, 0);
        end
`else
        tick();
        check_state("wrap_up", 0, 0, 1);
        check_val("wrap_up.hamming", $countones(gray ^ prev_gray), 1);
        en = 1'b0;
        tick();
        check_state("wrap_up_after", 0, 0, 0);
`endif

        // Load with en low, then load with en high at a would-wrap value
        en = 1'b0; load = 1'b1; load_bin = 4'd9;
        tick();
        check_state("load9", 9, 13, 0);
        load_bin = 4'd15;
        tick();
        check_state("load15", 15, 8, 0);
        en = 1'b1; up = 1'b1; load_bin = 4'd9;
        tick();
        check_state("load9_en", 9, 13, 0);

        // Down count from 0
        load_bin = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0; #1;
        check_val("down0.tc", int'(tc), 1);
`ifdef GRAY_COUNTER_SATURATE_EN
        tick();
        check_state("sat_down", 0, 0, 0);
        check_val("sat_down.tc", int'(tc), 1);
`else
        tick();
        check_state("wrap_down", 15, 8, 1);
        check_val("wrap_down.tc", int'(tc), 0);
        tick();
        check_state("down14", 14, 9, 0);
`endif

        // Idle hold, then direction changes
        en = 1'b0; load = 1'b1; load_bin = 4'd5;
        tick();
        load = 1'b0;
        tick();
        check_state("hold5", 5, 7, 0);
        en = 1'b1; up = 1'b1;
        tick();
        check_state("dir_up6", 6, 5, 0);
        up = 1'b0;
        tick();
        check_state("dir_down5", 5, 7, 0);
        up = 1'b1;
        tick();
        check_state("count6", 6, 5, 0);

        // Reset together with load and en
        rst = 1'b1; load = 1'b1; load_bin = 4'd3; en = 1'b1;
        tick();
        check_state("rst_over_load", 0, 0, 0);
        rst = 1'b0; load = 1'b0; en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
